mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-ported RAM.
// Data requests win by default; a starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  input  logic        halt,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        buserr
);

  localparam int CW = ($clog2(STARVE_LIMIT + 1) > 2) ? $clog2(STARVE_LIMIT + 1) : 2;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;

  logic        ireq_s, dreq_s;
  logic        ren_s, wen_s, ihit_s, dhit_s, buserr_s;
  logic [31:0] addr_s, store_s, iload_s, dload_s;

  assign ireq_s = iREN & ~halt;
  assign dreq_s = dREN | dWEN;

  // State and starvation counter registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, counter update and RAM/port outputs.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ren_s    = 1'b0;
    wen_s    = 1'b0;
    ihit_s   = 1'b0;
    dhit_s   = 1'b0;
    buserr_s = 1'b0;
    addr_s   = 32'h0000_0000;
    store_s  = 32'h0000_0000;
    iload_s  = 32'h0000_0000;
    dload_s  = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (!ireq_s) begin
          cnt_s = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r;
        end
        if (dreq_s && ireq_s && (cnt_r == LIMIT)) begin
          state_s = IACC;
        end else if (dreq_s) begin
          state_s = DACC;
        end else if (ireq_s) begin
          state_s = IACC;
        end else begin
          state_s = IDLE;
        end
      end
      IACC: begin
        // A withdrawn request aborts with strobes low, even if the RAM answers.
        if (!ireq_s) begin
          state_s = IDLE;
        end else begin
          ren_s  = 1'b1;
          addr_s = iaddr;
          case (ramstate)
            RAM_ACCESS: begin
              ihit_s  = 1'b1;
              iload_s = ramload;
              cnt_s   = {CW{1'b0}};
              state_s = IDLE;
            end
            RAM_ERROR: begin
              buserr_s = 1'b1;
              state_s  = IDLE;
            end
            default: begin
              state_s = IACC;
            end
          endcase
        end
      end
      DACC: begin
        if (!dreq_s) begin
          state_s = IDLE;
        end else begin
          addr_s  = daddr;
          store_s = dstore;
          if (dWEN) begin
            wen_s = 1'b1;
          end else begin
            ren_s = 1'b1;
          end
          case (ramstate)
            RAM_ACCESS: begin
              dhit_s  = 1'b1;
              dload_s = ramload;
              if (ireq_s && (cnt_r != LIMIT)) begin
                cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
              end else begin
                cnt_s = cnt_r;
              end
              state_s = IDLE;
            end
            RAM_ERROR: begin
              buserr_s = 1'b1;
              state_s  = IDLE;
            end
            default: begin
              state_s = DACC;
            end
          endcase
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks before the first edge.
  assign ramREN   = ~nRST & ren_s;
  assign ramWEN   = ~nRST & wen_s;
  assign ihit     = ~nRST & ihit_s;
  assign dhit     = ~nRST & dhit_s;
  assign buserr   = ~nRST & buserr_s;
  assign ramaddr  = nRST ? 32'h0000_0000 : addr_s;
  assign ramstore = nRST ? 32'h0000_0000 : store_s;
  assign iload    = nRST ? 32'h0000_0000 : iload_s;
  assign dload    = nRST ? 32'h0000_0000 : dload_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// all checked against a grant-owner reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 3;
  localparam int OWN_NONE = 0;
  localparam int OWN_INSTR = 1;
  localparam int OWN_DATA = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, halt;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, buserr;

  logic        s_rst, s_iren, s_dren, s_dwen, s_halt;
  logic [31:0] s_iaddr, s_daddr, s_dstore, s_load;
  logic [1:0]  s_state;

  logic        o_ihit, o_dhit, o_ramren, o_buserr;
  logic [31:0] o_iload, o_ramaddr;

  int n_checks = 0;
  int n_errors = 0;
  int m_owner = OWN_NONE;
  int m_cnt = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .buserr(buserr)
  );

  always #5 CLK = ~CLK;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, commit model at posedge.
  task automatic step();
    int          nxt, ncnt;
    bit          ireq, dreq;
    logic        e_ren, e_wen, e_ihit, e_dhit, e_berr;
    logic [31:0] e_addr, e_store, e_iload, e_dload;
    @(negedge CLK);
    nRST = s_rst; iREN = s_iren; iaddr = s_iaddr; dREN = s_dren; dWEN = s_dwen;
    daddr = s_daddr; dstore = s_dstore; halt = s_halt; ramstate = s_state; ramload = s_load;
    #1;
    ireq = s_iren && !s_halt;
    dreq = s_dren || s_dwen;
    {e_ren, e_wen, e_ihit, e_dhit, e_berr} = 5'b0;
    e_addr = 32'h0; e_store = 32'h0; e_iload = 32'h0; e_dload = 32'h0;
    nxt = m_owner;
    ncnt = m_cnt;
    if (s_rst) begin
      nxt = OWN_NONE;
      ncnt = 0;
    end else if (m_owner == OWN_NONE) begin
      if (!ireq) ncnt = 0;
      if (dreq && ireq && m_cnt == LIMIT) nxt = OWN_INSTR;
      else if (dreq) nxt = OWN_DATA;
      else if (ireq) nxt = OWN_INSTR;
      else nxt = OWN_NONE;
    end else if (m_owner == OWN_INSTR) begin
      if (!ireq) nxt = OWN_NONE;
      else begin
        e_ren = 1'b1;
        e_addr = s_iaddr;
        if (s_state == 2'd2) begin
          e_ihit = 1'b1; e_iload = s_load; ncnt = 0; nxt = OWN_NONE;
        end else if (s_state == 2'd3) begin
          e_berr = 1'b1; nxt = OWN_NONE;
        end
      end
    end else begin
      if (!dreq) nxt = OWN_NONE;
      else begin
        e_addr = s_daddr;
        e_store = s_dstore;
        if (s_dwen) e_wen = 1'b1;
        else e_ren = 1'b1;
        if (s_state == 2'd2) begin
          e_dhit = 1'b1; e_dload = s_load; nxt = OWN_NONE;
          if (ireq) ncnt = (m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1;
        end else if (s_state == 2'd3) begin
          e_berr = 1'b1; nxt = OWN_NONE;
        end
      end
    end
    check_value("strobes", {27'd0, ramREN, ramWEN, ihit, dhit, buserr},
                {27'd0, e_ren, e_wen, e_ihit, e_dhit, e_berr});
    check_value("ramaddr", ramaddr, e_addr);
    check_value("ramstore", ramstore, e_store);
    check_value("iload", iload, e_iload);
    check_value("dload", dload, e_dload);
    o_ihit = ihit; o_dhit = dhit; o_ramren = ramREN; o_buserr = buserr;
    o_iload = iload; o_ramaddr = ramaddr;
    @(posedge CLK);
    m_owner = nxt;
    m_cnt = ncnt;
  endtask

  task automatic clear_inputs();
    s_rst = 1'b0; s_iren = 1'b0; s_dren = 1'b0; s_dwen = 1'b0; s_halt = 1'b0;
    s_iaddr = 32'h0; s_daddr = 32'h0; s_dstore = 32'h0; s_load = 32'h0; s_state = 2'd0;
  endtask

  initial begin
    logic [31:0] seq;
    int r;
    clear_inputs();
    s_rst = 1'b1;
    step();
    step();
    s_rst = 1'b0;
    step();
    check_value("reset_ren", {31'd0, o_ramren}, 32'd0);

    // Instruction read with two wait states
    s_iren = 1'b1; s_iaddr = 32'h0000_0040; s_state = 2'd1;
    step();
    step();
    check_value("ifetch_ren", {31'd0, o_ramren}, 32'd1);
    check_value("ifetch_addr", o_ramaddr, 32'h0000_0040);
    step();
    s_state = 2'd2; s_load = 32'h2001_0005;
    step();
    check_value("ifetch_hit", {31'd0, o_ihit}, 32'd1);
    check_value("ifetch_load", o_iload, 32'h2001_0005);
    s_iren = 1'b0;
    step();
    check_value("ifetch_idle", {31'd0, o_ramren}, 32'd0);

    // Simultaneous requests: data first
    s_iren = 1'b1; s_dren = 1'b1; s_daddr = 32'h0000_0100; s_state = 2'd2;
    step();
    step();
    check_value("simul_dhit", {31'd0, o_dhit}, 32'd1);
    check_value("simul_daddr", o_ramaddr, 32'h0000_0100);
    s_dren = 1'b0;
    step();
    step();
    check_value("simul_ihit", {31'd0, o_ihit}, 32'd1);

    // Starvation: grant order of hits with instruction held
    clear_inputs();
    step();
    s_iren = 1'b1; s_dwen = 1'b1; s_state = 2'd2;
    seq = 32'h0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (o_dhit) seq = {seq[27:0], 4'hD};
      else if (o_ihit) seq = {seq[27:0], 4'h1};
    end
    check_value("starve_order", seq, 32'hDDD1_DDD1);

    // Bus error then retry
    clear_inputs();
    step();
    s_dwen = 1'b1; s_daddr = 32'h0000_0200; s_dstore = 32'hCAFE_0001; s_state = 2'd3;
    step();
    step();
    check_value("err_buserr", {31'd0, o_buserr}, 32'd1);
    check_value("err_nohit", {31'd0, o_dhit}, 32'd0);
    s_state = 2'd2;
    step();
    step();
    check_value("err_retry_hit", {31'd0, o_dhit}, 32'd1);

    // Halt aborts an instruction access
    clear_inputs();
    s_iren = 1'b1; s_state = 2'd1;
    step();
    step();
    s_halt = 1'b1;
    step();
    check_value("halt_ren", {31'd0, o_ramren}, 32'd0);
    check_value("halt_nohit", {31'd0, o_ihit}, 32'd0);
    step();
    check_value("halt_idle", {31'd0, o_ramren}, 32'd0);

    // Reset during a data wait
    clear_inputs();
    s_dren = 1'b1; s_daddr = 32'h0000_0300; s_state = 2'd1;
    step();
    step();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    step();
    check_value("rst_idle_ren", {31'd0, o_ramren}, 32'd0);
    s_state = 2'd2;
    step();
    check_value("rst_regrant_hit", {31'd0, o_dhit}, 32'd1);

    // Randomized traffic
    clear_inputs();
    for (int k = 0; k < 3000; k++) begin
      s_rst    = ($urandom_range(0, 99) == 0);
      s_iren   = ($urandom_range(0, 99) < 85);
      s_halt   = ($urandom_range(0, 99) < 10);
      s_dren   = ($urandom_range(0, 99) < 40);
      s_dwen   = ($urandom_range(0, 99) < 30);
      s_iaddr  = $urandom;
      s_daddr  = $urandom;
      s_dstore = $urandom;
      s_load   = $urandom;
      r = $urandom_range(0, 19);
      if (r < 5) s_state = 2'd0;
      else if (r < 10) s_state = 2'd1;
      else if (r < 17) s_state = 2'd2;
      else s_state = 2'd3;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
